// File: rtl/axi_rd_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : axi_rd_arb                                                      |
// | Purpose  : N-channel AXI3 read arbiter. Grants AR requests, tags them with |
// |            the channel index in ARID, and routes R beats back by RID.      |
// | Config   : AXI_RD_ARB_FIXED_PRIO_EN selects fixed priority (lowest index   |
// |            wins) instead of the default round-robin.                       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module axi_rd_arb #(
   parameter int NUM_CHANS   = 2,
   parameter int ADDR_BITS   = 32,
   parameter int DATA_BITS   = 64,
   parameter int ID_BITS     = 4,
   parameter int MAX_PENDING = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_CHANS-1:0]           slv_arvalid,
   output logic [NUM_CHANS-1:0]           slv_arready,
   input  logic [NUM_CHANS*ADDR_BITS-1:0] slv_araddr,
   input  logic [NUM_CHANS*4-1:0]         slv_arlen,
   input  logic [NUM_CHANS*3-1:0]         slv_arsize,
   input  logic [NUM_CHANS*2-1:0]         slv_arburst,
   output logic [NUM_CHANS-1:0]           slv_rvalid,
   input  logic [NUM_CHANS-1:0]           slv_rready,
   output logic [DATA_BITS-1:0]           slv_rdata,
   output logic [1:0]                     slv_rresp,
   output logic                           slv_rlast,
   output logic                           mst_arvalid,
   input  logic                           mst_arready,
   output logic [ID_BITS-1:0]             mst_arid,
   output logic [ADDR_BITS-1:0]           mst_araddr,
   output logic [3:0]                     mst_arlen,
   output logic [2:0]                     mst_arsize,
   output logic [1:0]                     mst_arburst,
   output logic [1:0]                     mst_arlock,
   input  logic                           mst_rvalid,
   output logic                           mst_rready,
   input  logic [ID_BITS-1:0]             mst_rid,
   input  logic [DATA_BITS-1:0]           mst_rdata,
   input  logic [1:0]                     mst_rresp,
   input  logic                           mst_rlast,
   output logic                           err_badid
);

   localparam int CNT_W = $clog2(MAX_PENDING + 1);
   localparam int CH_W  = (NUM_CHANS > 1) ? $clog2(NUM_CHANS) : 1;
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PENDING);

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   logic [0:0]           ar_state_q, ar_state_d;
   logic [ID_BITS-1:0]   arid_q, arid_d;
   logic [ADDR_BITS-1:0] araddr_q, araddr_d;
   logic [3:0]           arlen_q, arlen_d;
   logic [2:0]           arsize_q, arsize_d;
   logic [1:0]           arburst_q, arburst_d;
   logic                 err_badid_q, err_badid_d;
   logic [CNT_W-1:0]     pending_q [NUM_CHANS];
   logic [CNT_W-1:0]     pending_d [NUM_CHANS];

   logic [NUM_CHANS-1:0] eligible;
   logic                 can_grant, grant, grant_hit;
   logic [CH_W-1:0]      winner;
   logic                 rid_ok, sel_rready, r_done;

   always_comb begin
      can_grant = !rst && ((ar_state_q == ST_EMPTY) || mst_arready);
      for (int i = 0; i < NUM_CHANS; i++) begin
         eligible[i] = slv_arvalid[i] && (pending_q[i] < MAX_CNT);
      end
   end

`ifdef AXI_RD_ARB_FIXED_PRIO_EN
   always_comb begin
      grant_hit = 1'b0;
      winner    = '0;
      for (int i = NUM_CHANS - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            grant_hit = 1'b1;
            winner    = CH_W'(i);
         end
      end
   end
`else
   logic [CH_W-1:0] ptr_q, ptr_d;
   logic            hi_hit;
   logic [CH_W-1:0] hi_win;

   // Lowest eligible index at or above ptr wins; otherwise wrap to lowest overall.
   always_comb begin
      grant_hit = 1'b0;
      winner    = '0;
      hi_hit    = 1'b0;
      hi_win    = '0;
      for (int i = NUM_CHANS - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            grant_hit = 1'b1;
            winner    = CH_W'(i);
            if (CH_W'(i) >= ptr_q) begin
               hi_hit = 1'b1;
               hi_win = CH_W'(i);
            end
         end
      end
      if (hi_hit) winner = hi_win;
      ptr_d = ptr_q;
      if (grant) ptr_d = (winner == CH_W'(NUM_CHANS - 1)) ? '0 : winner + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end
`endif

   always_comb begin
      grant = can_grant && grant_hit;
      for (int i = 0; i < NUM_CHANS; i++) begin
         slv_arready[i] = grant && (winner == CH_W'(i));
      end

      ar_state_d = ar_state_q;
      arid_d     = arid_q;
      araddr_d   = araddr_q;
      arlen_d    = arlen_q;
      arsize_d   = arsize_q;
      arburst_d  = arburst_q;
      if (grant) begin
         ar_state_d = ST_FULL;
         arid_d     = ID_BITS'(winner);
         araddr_d   = slv_araddr[winner*ADDR_BITS +: ADDR_BITS];
         arlen_d    = slv_arlen[winner*4 +: 4];
         arsize_d   = slv_arsize[winner*3 +: 3];
         arburst_d  = slv_arburst[winner*2 +: 2];
      end else if ((ar_state_q == ST_FULL) && mst_arready) begin
         ar_state_d = ST_EMPTY;
      end
   end

   // Unknown RIDs are accepted and dropped so the slave can never stall on them.
   always_comb begin
      rid_ok     = 1'b0;
      sel_rready = 1'b1;
      slv_rvalid = '0;
      for (int i = 0; i < NUM_CHANS; i++) begin
         if (mst_rid == ID_BITS'(i)) begin
            rid_ok        = 1'b1;
            sel_rready    = slv_rready[i];
            slv_rvalid[i] = mst_rvalid && !rst;
         end
      end
      mst_rready  = !rst && sel_rready;
      r_done      = mst_rvalid && mst_rready && mst_rlast;
      err_badid_d = err_badid_q || (mst_rvalid && !rid_ok && !rst);

      for (int i = 0; i < NUM_CHANS; i++) begin
         pending_d[i] = pending_q[i];
         if (slv_arready[i] && !(r_done && rid_ok && (mst_rid == ID_BITS'(i)) && (pending_q[i] != '0))) begin
            pending_d[i] = pending_q[i] + CNT_W'(1);
         end else if (!slv_arready[i] && r_done && (mst_rid == ID_BITS'(i)) && (pending_q[i] != '0)) begin
            pending_d[i] = pending_q[i] - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ar_state_q  <= ST_EMPTY;
         arid_q      <= '0;
         araddr_q    <= '0;
         arlen_q     <= '0;
         arsize_q    <= '0;
         arburst_q   <= '0;
         err_badid_q <= 1'b0;
         for (int i = 0; i < NUM_CHANS; i++) pending_q[i] <= '0;
      end else begin
         ar_state_q  <= ar_state_d;
         arid_q      <= arid_d;
         araddr_q    <= araddr_d;
         arlen_q     <= arlen_d;
         arsize_q    <= arsize_d;
         arburst_q   <= arburst_d;
         err_badid_q <= err_badid_d;
         for (int i = 0; i < NUM_CHANS; i++) pending_q[i] <= pending_d[i];
      end
   end

   assign mst_arvalid = (ar_state_q == ST_FULL);
   assign mst_arid    = arid_q;
   assign mst_araddr  = araddr_q;
   assign mst_arlen   = arlen_q;
   assign mst_arsize  = arsize_q;
   assign mst_arburst = arburst_q;
   assign mst_arlock  = 2'b00;
   assign slv_rdata   = mst_rdata;
   assign slv_rresp   = mst_rresp;
   assign slv_rlast   = mst_rlast;
   assign err_badid   = err_badid_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_axi_rd_arb                                                   |
// | Purpose  : Self-checking bench for axi_rd_arb (AR arbitration, pending     |
// |            limits, R routing, bad-RID handling, mid-operation reset).      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_axi_rd_arb;

   localparam int NC = 2;
   localparam int AW = 32;
   localparam int DW = 64;
   localparam int IW = 4;
   localparam int MP = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [NC-1:0]    slv_arvalid, slv_arready, slv_rvalid, slv_rready;
   logic [NC*AW-1:0] slv_araddr;
   logic [NC*4-1:0]  slv_arlen;
   logic [NC*3-1:0]  slv_arsize;
   logic [NC*2-1:0]  slv_arburst;
   logic [DW-1:0]    slv_rdata, mst_rdata;
   logic [1:0]       slv_rresp, mst_rresp;
   logic             slv_rlast, mst_rlast;
   logic             mst_arvalid, mst_arready;
   logic [IW-1:0]    mst_arid, mst_rid;
   logic [AW-1:0]    mst_araddr;
   logic [3:0]       mst_arlen;
   logic [2:0]       mst_arsize;
   logic [1:0]       mst_arburst, mst_arlock;
   logic             mst_rvalid, mst_rready;
   logic             err_badid;

   axi_rd_arb #(
      .NUM_CHANS(NC), .ADDR_BITS(AW), .DATA_BITS(DW), .ID_BITS(IW), .MAX_PENDING(MP)
   ) dut (
      .clk(clk), .rst(rst),
      .slv_arvalid(slv_arvalid), .slv_arready(slv_arready), .slv_araddr(slv_araddr),
      .slv_arlen(slv_arlen), .slv_arsize(slv_arsize), .slv_arburst(slv_arburst),
      .slv_rvalid(slv_rvalid), .slv_rready(slv_rready), .slv_rdata(slv_rdata),
      .slv_rresp(slv_rresp), .slv_rlast(slv_rlast),
      .mst_arvalid(mst_arvalid), .mst_arready(mst_arready), .mst_arid(mst_arid),
      .mst_araddr(mst_araddr), .mst_arlen(mst_arlen), .mst_arsize(mst_arsize),
      .mst_arburst(mst_arburst), .mst_arlock(mst_arlock),
      .mst_rvalid(mst_rvalid), .mst_rready(mst_rready), .mst_rid(mst_rid),
      .mst_rdata(mst_rdata), .mst_rresp(mst_rresp), .mst_rlast(mst_rlast),
      .err_badid(err_badid)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic          rvalid;
      logic [IW-1:0] rid;
      logic [NC-1:0] rready;
      logic [DW-1:0] data;
      logic [NC-1:0] exp_rvalid;
      logic          exp_rready;
   } rvec_t;

   rvec_t vecs [5];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      step;
      step;
      rst = 1'b0;
   endtask

   int prev_win;
   int exp_win;

   initial begin
      vecs[0] = '{1'b1, 4'd1, 2'b10, 64'h1111, 2'b10, 1'b1};
      vecs[1] = '{1'b1, 4'd0, 2'b10, 64'h2222, 2'b01, 1'b0};
      vecs[2] = '{1'b1, 4'd1, 2'b10, 64'h3333, 2'b10, 1'b1};
      vecs[3] = '{1'b0, 4'd0, 2'b11, 64'h4444, 2'b00, 1'b1};
      vecs[4] = '{1'b1, 4'd0, 2'b01, 64'h5555, 2'b01, 1'b1};

      slv_araddr  = {32'h0000_0200, 32'h0000_0100};
      slv_arlen   = {4'd7, 4'd3};
      slv_arsize  = {3'd2, 3'd3};
      slv_arburst = {2'd1, 2'd1};
      mst_rdata   = '0;
      mst_rresp   = 2'b00;
      mst_rlast   = 1'b0;
      mst_rid     = '0;
      mst_arready = 1'b0;

      // Reset with active inputs: combinational outputs must stay quiet
      rst         = 1'b1;
      slv_arvalid = 2'b11;
      slv_rready  = 2'b11;
      mst_rvalid  = 1'b1;
      step;
      step;
      @(negedge clk);
      chk("rst_slv_arready", slv_arready, 2'b00);
      chk("rst_slv_rvalid", slv_rvalid, 2'b00);
      chk("rst_mst_rready", mst_rready, 1'b0);
      chk("rst_mst_arvalid", mst_arvalid, 1'b0);
      chk("rst_fields", {mst_arid, mst_arlen, mst_arsize, mst_arburst, mst_arlock}, '0);
      chk("rst_araddr", mst_araddr, '0);
      chk("rst_err", err_badid, 1'b0);
      slv_arvalid = 2'b00;
      slv_rready  = 2'b00;
      mst_rvalid  = 1'b0;
      step;
      rst = 1'b0;

      // Single channel 0 request, then a stalled register with ch1 waiting
      slv_arvalid = 2'b01;
      @(negedge clk);
      chk("t1_grant0", slv_arready, 2'b01);
      step;
      slv_arvalid = 2'b10;
      @(negedge clk);
      chk("t1_arvalid", mst_arvalid, 1'b1);
      chk("t1_arid", mst_arid, 4'd0);
      chk("t1_araddr", mst_araddr, 32'h100);
      chk("t1_arlen_size_burst", {mst_arlen, mst_arsize, mst_arburst}, {4'd3, 3'd3, 2'd1});
      chk("t1_no_grant_stalled", slv_arready, 2'b00);
      step;
      @(negedge clk);
      chk("t1_araddr_stable", mst_araddr, 32'h100);
      chk("t1_arid_stable", mst_arid, 4'd0);
      mst_arready = 1'b1;
      #1;
      chk("t1_grant1_on_drain", slv_arready, 2'b10);
      step;
      slv_arvalid = 2'b00;
      @(negedge clk);
      chk("t1_full_kept", mst_arvalid, 1'b1);
      chk("t1_arid1", mst_arid, 4'd1);
      chk("t1_araddr1", mst_araddr, 32'h200);
      chk("t1_arlen1", mst_arlen, 4'd7);
      step;
      @(negedge clk);
      chk("t1_empty", mst_arvalid, 1'b0);
      mst_arready = 1'b0;

      // Four R beats for channel 0
      slv_rready = 2'b11;
      for (int b = 0; b < 4; b++) begin
         step;
         mst_rvalid = 1'b1;
         mst_rid    = 4'd0;
         mst_rlast  = (b == 3);
         mst_rdata  = 64'hA0 + 64'(b);
         @(negedge clk);
         chk("t1_r_rvalid", slv_rvalid, 2'b01);
         chk("t1_r_rready", mst_rready, 1'b1);
         chk("t1_r_data", slv_rdata, 64'hA0 + 64'(b));
         chk("t1_r_last", slv_rlast, (b == 3) ? 1'b1 : 1'b0);
      end
      step;
      mst_rvalid = 1'b0;
      mst_rlast  = 1'b0;

      // Both channels requesting continuously
      do_reset;
      slv_arvalid = 2'b11;
      mst_arready = 1'b1;
      prev_win    = -1;
      for (int k = 0; k < 4; k++) begin
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
         exp_win = 0;
`else
         exp_win = k % 2;
`endif
         @(negedge clk);
         chk("t2_grant", slv_arready, 64'(1) << exp_win);
         if (prev_win >= 0) chk("t2_arid", mst_arid, 64'(prev_win));
         prev_win = exp_win;
         step;
      end
      slv_arvalid = 2'b00;
      @(negedge clk);
      chk("t2_arid_last", mst_arid, 64'(prev_win));

      // Channel 1 fills its pending budget, channel 0 still served
      do_reset;
      slv_arvalid = 2'b10;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t3_grant1", slv_arready, 2'b10);
         step;
      end
      slv_arvalid = 2'b11;
      @(negedge clk);
      chk("t3_full_ch1_ch0_wins", slv_arready, 2'b01);
      step;
      slv_arvalid = 2'b10;
      @(negedge clk);
      chk("t3_ch1_blocked", slv_arready, 2'b00);
      step;
      mst_rvalid = 1'b1;
      mst_rid    = 4'd1;
      mst_rlast  = 1'b1;
      slv_rready = 2'b10;
      @(negedge clk);
      chk("t3_rlast_rvalid", slv_rvalid, 2'b10);
      chk("t3_still_blocked", slv_arready, 2'b00);
      step;
      mst_rvalid = 1'b0;
      mst_rlast  = 1'b0;
      @(negedge clk);
      chk("t3_fifth_grant", slv_arready, 2'b10);
      step;
      slv_arvalid = 2'b00;

      // R routing vectors
      for (int v = 0; v < 5; v++) begin
         mst_rvalid = vecs[v].rvalid;
         mst_rid    = vecs[v].rid;
         slv_rready = vecs[v].rready;
         mst_rdata  = vecs[v].data;
         @(negedge clk);
         chk($sformatf("t4_rvalid_v%0d", v), slv_rvalid, vecs[v].exp_rvalid);
         chk($sformatf("t4_rready_v%0d", v), mst_rready, vecs[v].exp_rready);
         chk($sformatf("t4_rdata_v%0d", v), slv_rdata, vecs[v].data);
         step;
      end
      mst_rvalid = 1'b0;

      // Out-of-range RID
      chk("t5_err_before", err_badid, 1'b0);
      mst_rvalid = 1'b1;
      mst_rid    = 4'd5;
      slv_rready = 2'b00;
      @(negedge clk);
      chk("t5_no_rvalid", slv_rvalid, 2'b00);
      chk("t5_dropped", mst_rready, 1'b1);
      step;
      mst_rvalid = 1'b0;
      mst_rid    = 4'd0;
      @(negedge clk);
      chk("t5_err_set", err_badid, 1'b1);
      step;
      step;
      @(negedge clk);
      chk("t5_err_held", err_badid, 1'b1);

      // Reset with a burst in the AR register and pending nonzero
      step;
      slv_arvalid = 2'b01;
      mst_arready = 1'b0;
      step;
      slv_arvalid = 2'b00;
      @(negedge clk);
      chk("t6_pre_arvalid", mst_arvalid, 1'b1);
      rst         = 1'b1;
      slv_arvalid = 2'b11;
      slv_rready  = 2'b11;
      mst_rvalid  = 1'b1;
      #1;
      chk("t6_rst_arready", slv_arready, 2'b00);
      chk("t6_rst_rready", mst_rready, 1'b0);
      chk("t6_rst_rvalid", slv_rvalid, 2'b00);
      step;
      @(negedge clk);
      chk("t6_arvalid", mst_arvalid, 1'b0);
      chk("t6_arid_addr", {mst_arid, mst_araddr}, '0);
      chk("t6_err_cleared", err_badid, 1'b0);
      rst         = 1'b0;
      mst_rvalid  = 1'b0;
      mst_arready = 1'b1;
      #1;
      chk("t6_first_grant_ch0", slv_arready, 2'b01);
      step;
      slv_arvalid = 2'b10;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t6_ch1_pending_cleared", slv_arready, 2'b10);
         step;
      end
      slv_arvalid = 2'b00;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/axi_rd_arb.md
# axi_rd_arb

N-channel AXI3 read-address/read-data arbiter that lets several memory-to-stream DMA channels share one AXI read master port toward memory. It arbitrates AR requests, tags each burst with the channel index in ARID, tracks outstanding bursts per channel, and routes R beats back by RID. It sits between the per-channel DMA read engines and the interconnect/memory slave in the multi-channel DMA wrapper.

## Interface
- NumChans, 2, number of upstream read channels, 1..2^IdBits
- AddrBits, 32, AXI address width
- DataBits, 64, AXI data width
- IdBits, 4, master ARID/RID width
- MaxPending, 4, max outstanding bursts per channel, ≥1

Reset rst, synchronous, active-high; clock clk.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- slv_arvalid  in  NumChans  per-channel AR valid
- slv_arready  out  NumChans  per-channel AR ready
- slv_araddr  in  NumChans*AddrBits  channel i at [i*AddrBits +: AddrBits]
- slv_arlen  in  NumChans*4  burst length-1
- slv_arsize  in  NumChans*3  beat size
- slv_arburst  in  NumChans*2  burst type
- slv_rvalid  out  NumChans  per-channel R valid
- slv_rready  in  NumChans  per-channel R ready
- slv_rdata  out  DataBits  R data, broadcast to all channels
- slv_rresp  out  2  R response, broadcast
- slv_rlast  out  1  R last, broadcast
- mst_arvalid/mst_arready  out/in  1  master AR handshake
- mst_arid  out  IdBits  channel index, zero-extended
- mst_araddr/arlen/arsize/arburst  out  AddrBits/4/3/2  registered AR fields
- mst_arlock  out  2  constant 0
- mst_rvalid/mst_rready  in/out  1  master R handshake
- mst_rid  in  IdBits  routing tag
- mst_rdata/mst_rresp/mst_rlast  in  DataBits/2/1  R payload
- err_badid  out  1  sticky: R beat arrived with RID ≥ NumChans

## Operation
- AR output register, states EMPTY / FULL. EMPTY → FULL on grant; FULL → EMPTY on mst_arvalid&&mst_arready with no new grant; FULL stays FULL if a new grant occurs in the draining cycle.
- Grant allowed when register EMPTY or draining this cycle. Eligible channel i: slv_arvalid[i] && pending[i] < MaxPending.
- Round-robin: search starts at ptr; winner gets slv_arready[winner]=1 for that cycle (combinational, at most one bit set); fields and arid=winner loaded; ptr ← (winner+1) mod NumChans.
- pending[i], width clog2(MaxPending+1): +1 on slv AR handshake of i, −1 on mst R handshake with rlast and RID=i; both in same cycle → unchanged. Never exceeds MaxPending, never underflows.
- R routing combinational: c = mst_rid; slv_rvalid[i] = mst_rvalid && c==i; mst_rready = slv_rready[c]. Payload passes straight through.
- RID ≥ NumChans: mst_rready=1 (beat dropped), no slv_rvalid, err_badid set until reset.
- Reset mid-operation: register emptied, all pending cleared, ptr=0; in-flight bursts are abandoned (system resets slave concurrently).

## Timing
- Reset values: slv_arready=0, slv_rvalid=0, mst_arvalid=0, mst_arid/araddr/arlen/arsize/arburst=0, mst_arlock=0, mst_rready=0, err_badid=0.
- AR latency: slv handshake cycle t → mst_arvalid high t+1. Sustained throughput 1 AR/cycle when mst_arready held high.
- mst_ar* stable while mst_arvalid && !mst_arready.
- R path zero latency; no buffering.

## Configuration
- AXI_RD_ARB_FIXED_PRIO_EN defined: fixed priority, lowest eligible index always wins, ptr not implemented.
- Undefined (default): round-robin as above.

## Test plan
- Single channel 0, arlen=3, addr 0x100 → mst_arid=0, mst_araddr=0x100 one cycle after grant; 4 R beats reach channel 0 only, pending 1→0 on rlast.
- Both channels arvalid continuously, mst_arready=1 → grants alternate 0,1,0,1 (round-robin); with macro defined → channel 0 always.
- Channel 1 issues 4 ARs, slave withholds R → pending[1]=4, slv_arready[1] stays 0 while channel 0 still granted; first rlast for ID 1 → fifth AR granted.
- Interleaved R beats RID 1,0,1 with slv_rready[0]=0 → mst_rready low only on RID-0 beat, data delivered in order per channel.
- R beat with RID=5, NumChans=2 → consumed, no slv_rvalid, err_badid=1 and held.
- Assert rst with mst_arvalid high and pending nonzero → next cycle all outputs at reset values, pending 0, first grant after reset goes to channel 0.
